fetch_prefetch_unit: RTL



---
 rtl/fetch_prefetch_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
//   Instruction-fetch front end ahead of the Fetch/Decode register. It owns the
//   fetch PC, issues addresses to a synchronous ROM with a 1-cycle read latency,
//   buffers {instruction, pc} pairs in a small FIFO, and presents the FIFO head
//   to decode. Stalls hold the head. A redirect flushes the FIFO and refetches.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high
//   stall          in   decode cannot accept the head this cycle
//   redirect_valid in   taken branch in decode: flush and refetch
//   redirect_addr  in   branch target [ADDR_WIDTH]
//   rom_req        out  rom_address is a live request this cycle
//   rom_address    out  ROM address [ADDR_WIDTH]
//   rom_q          in   ROM data for the address issued last cycle [DATA_WIDTH]
//   instr_valid    out  FIFO head is valid
//   instr_out      out  instruction at the FIFO head [DATA_WIDTH]
//   pc_out         out  PC of instr_out [ADDR_WIDTH]
module fetch_prefetch_unit #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  rom_req,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0] pc_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_fetch_q, pc_fetch_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_d   [DEPTH];

    logic [CNT_W:0] occupancy;
    logic           pop;

    // Credit counts the buffered entries plus the one request whose data is
    // still on its way back, so every returning word has a free slot.
    assign occupancy   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign rom_req     = !reset && !redirect_valid && (occupancy < DEPTH_L);
    assign rom_address = reset ? RESET_PC : pc_fetch_q;

    // Gating with reset keeps the outputs at their idle values for the whole
    // time reset is held, including the first cycle before state is cleared.
    assign instr_valid = !reset && (count_q != '0);
    assign instr_out   = instr_valid ? data_mem_q[rd_ptr_q] : '0;
    assign pc_out      = instr_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign pop         = instr_valid && !stall && !redirect_valid;

    always_comb begin
        pc_fetch_d    = pc_fetch_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        data_mem_d    = data_mem_q;
        pc_mem_d      = pc_mem_q;

        if (redirect_valid) begin
            // Flush: the word returning this cycle belongs to the wrong path
            // and is dropped by leaving inflight clear.
            pc_fetch_d = redirect_addr;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (rom_req) begin
                pc_fetch_d    = pc_fetch_q + ADDR_WIDTH'(1);
                inflight_d    = 1'b1;
                inflight_pc_d = pc_fetch_q;
            end
            if (inflight_q) begin
                data_mem_d[wr_ptr_q] = rom_q;
                pc_mem_d[wr_ptr_q]   = inflight_pc_q;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({inflight_q, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_fetch_q <= RESET_PC;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            pc_fetch_q <= pc_fetch_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count/inflight.
    always_ff @(posedge clk) begin
        inflight_pc_q <= inflight_pc_d;
        data_mem_q    <= data_mem_d;
        pc_mem_q      <= pc_mem_d;
    end

endmodule
